// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Opcode map, instruction field layout and shared types for the
//               ctrl_seq instruction sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_LDI    = 4'h1;
    localparam logic [3:0] OP_ALU_LO = 4'h2;
    localparam logic [3:0] OP_ALU_HI = 4'h9;

    localparam int INS_W   = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 10;
    localparam int RA_MSB  = 9;
    localparam int RA_LSB  = 8;
    localparam int RB_MSB  = 7;
    localparam int RB_LSB  = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
        logic [1:0] ra;
        logic [1:0] rb;
        logic [7:0] imm;
        logic       is_nop;
        logic       is_ldi;
        logic       is_alu;
        logic       is_ill;
    } dec_t;

    // Only the fields still needed after the accept edge are kept.
    typedef struct packed {
        logic [3:0] op;
        logic [1:0] rd;
    } ins_lat_t;

endpackage
`default_nettype wire

// File: rtl/ins_dec.sv
`default_nettype none
// ============================================================================
// Module      : ins_dec
// Description : Combinational instruction decoder: splits the 16-bit word into
//               its fields and classifies the opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module ins_dec
    import ctrl_pkg::*;
(
    input  logic [INS_W-1:0] i_ins,
    output dec_t             o_dec
);

    logic [3:0] w_op;

    assign w_op = i_ins[OP_MSB:OP_LSB];

    always_comb begin
        o_dec        = '0;
        o_dec.op     = w_op;
        o_dec.rd     = i_ins[RD_MSB:RD_LSB];
        o_dec.ra     = i_ins[RA_MSB:RA_LSB];
        o_dec.rb     = i_ins[RB_MSB:RB_LSB];
        o_dec.imm    = i_ins[IMM_MSB:IMM_LSB];
        o_dec.is_nop = (w_op == OP_NOP);
        o_dec.is_ldi = (w_op == OP_LDI);
        o_dec.is_alu = (w_op >= OP_ALU_LO) && (w_op <= OP_ALU_HI);
        o_dec.is_ill = (w_op > OP_ALU_HI);
    end

endmodule
`default_nettype wire

// File: rtl/ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_seq
// Description : Multi-cycle sequencer driving a 4x8 register file through
//               READ -> EXEC -> WB, with a direct path to WB for LDI.
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_seq
    import ctrl_pkg::*;
#(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INS_W-1:0] ins,
    input  logic             ins_valid,
    output logic             ins_ready,
    input  logic [W-1:0]     alu_y,
    output logic [1:0]       DIR_A,
    output logic [1:0]       DIR_B,
    output logic [1:0]       DIR_WR,
    output logic             EN,
    output logic [W-1:0]     DI,
    output logic [3:0]       alu_op,
    output logic             done,
    output logic             ill
);

    state_t   r_state_q,  w_state_d;
    ins_lat_t r_ins_q,    w_ins_d;
    logic [W-1:0] r_result_q, w_result_d;
    logic [1:0]   r_dir_a_q,  w_dir_a_d;
    logic [1:0]   r_dir_b_q,  w_dir_b_d;
    logic [1:0]   r_dir_wr_q, w_dir_wr_d;
    logic [3:0]   r_alu_op_q, w_alu_op_d;
    logic         r_en_q,     w_en_d;
    logic         r_done_q,   w_done_d;
    logic         r_ill_q,    w_ill_d;

    dec_t w_dec;
    logic w_accept;

    ins_dec u_ins_dec (
        .i_ins (ins),
        .o_dec (w_dec)
    );

    // Ready is held low during reset even though the state is already IDLE.
    assign ins_ready = (r_state_q == ST_IDLE) && !rst;
    assign w_accept  = ins_ready && ins_valid;

    always_comb begin
        w_state_d  = r_state_q;
        w_ins_d    = r_ins_q;
        w_result_d = r_result_q;
        w_dir_a_d  = r_dir_a_q;
        w_dir_b_d  = r_dir_b_q;
        w_dir_wr_d = r_dir_wr_q;
        w_alu_op_d = r_alu_op_q;
        w_en_d     = 1'b0;
        w_done_d   = 1'b0;
        w_ill_d    = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_ins_d.op = w_dec.op;
                    w_ins_d.rd = w_dec.rd;
                    if (w_dec.is_alu) begin
                        w_state_d = ST_READ;
                        w_dir_a_d = w_dec.ra;
                        w_dir_b_d = w_dec.rb;
                    end else if (w_dec.is_ldi) begin
                        w_state_d  = ST_WB;
                        w_dir_wr_d = w_dec.rd;
                        w_result_d = W'(w_dec.imm);
                        w_en_d     = 1'b1;
                        w_done_d   = 1'b1;
                    end else begin
                        // NOP and illegal retire without leaving IDLE.
                        w_done_d = w_dec.is_nop | w_dec.is_ill;
                        w_ill_d  = w_dec.is_ill;
                    end
                end
            end
            ST_READ: begin
                w_state_d  = ST_EXEC;
                w_alu_op_d = r_ins_q.op;
            end
            ST_EXEC: begin
                // Registered write controls make WB a pure output-decode cycle.
                w_state_d  = ST_WB;
                w_result_d = alu_y;
                w_dir_wr_d = r_ins_q.rd;
                w_en_d     = 1'b1;
                w_done_d   = 1'b1;
            end
            ST_WB: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= ST_IDLE;
            r_ins_q    <= '0;
            r_result_q <= '0;
            r_dir_a_q  <= '0;
            r_dir_b_q  <= '0;
            r_dir_wr_q <= '0;
            r_alu_op_q <= '0;
            r_en_q     <= 1'b0;
            r_done_q   <= 1'b0;
            r_ill_q    <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_ins_q    <= w_ins_d;
            r_result_q <= w_result_d;
            r_dir_a_q  <= w_dir_a_d;
            r_dir_b_q  <= w_dir_b_d;
            r_dir_wr_q <= w_dir_wr_d;
            r_alu_op_q <= w_alu_op_d;
            r_en_q     <= w_en_d;
            r_done_q   <= w_done_d;
            r_ill_q    <= w_ill_d;
        end
    end

    assign DIR_A  = r_dir_a_q;
    assign DIR_B  = r_dir_b_q;
    assign DIR_WR = r_dir_wr_q;
    assign EN     = r_en_q;
    assign DI     = r_result_q;
    assign alu_op = r_alu_op_q;
    assign done   = r_done_q;
    assign ill    = r_ill_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_seq
// Description : Directed, scoreboard-checked bench for the ctrl_seq sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [15:0]  ins;
    logic         ins_valid;
    logic         ins_ready;
    logic [W-1:0] alu_y;
    logic [1:0]   DIR_A;
    logic [1:0]   DIR_B;
    logic [1:0]   DIR_WR;
    logic         EN;
    logic [W-1:0] DI;
    logic [3:0]   alu_op;
    logic         done;
    logic         ill;

    typedef struct packed {
        logic       en;
        logic [1:0] wr;
        logic [7:0] di;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_err    = 0;

    logic [20:0] outs_w;
    assign outs_w = {EN, DIR_A, DIR_B, DIR_WR, DI, alu_op, done, ill};

    ctrl_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ins       (ins),
        .ins_valid (ins_valid),
        .ins_ready (ins_ready),
        .alu_y     (alu_y),
        .DIR_A     (DIR_A),
        .DIR_B     (DIR_B),
        .DIR_WR    (DIR_WR),
        .EN        (EN),
        .DI        (DI),
        .alu_op    (alu_op),
        .done      (done),
        .ill       (ill)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic en, input logic [1:0] wr, input logic [7:0] di, input logic il);
        exp_t e;
        e.en  = en;
        e.wr  = wr;
        e.di  = di;
        e.ill = il;
        return e;
    endfunction

    // Accept log: the handshake seen at negedge is consumed by the next edge.
    always @(negedge clk) begin
        if (!rst && ins_valid && ins_ready) acc_q.push_back(cyc);
    end

    // Scoreboard monitor: every retirement pops one expected response.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("sb_en", 32'(EN), 32'(e.en));
                check("sb_ill", 32'(ill), 32'(e.ill));
                if (e.en) begin
                    check("sb_wr_addr", 32'(DIR_WR), 32'(e.wr));
                    check("sb_wr_data", 32'(DI), 32'(e.di));
                end
            end
        end
        if (!rst && EN) check("en_without_done", 32'(done), 32'(1));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        ins       = '0;
        ins_valid = 1'b0;
        alu_y     = '0;
        tick();
        tick();
        check("reset_outputs", 32'(outs_w), 32'(0));
        check("reset_ready", 32'(ins_ready), 32'(0));
        rst = 1'b0;
        #1;
        check("ready_after_reset", 32'(ins_ready), 32'(1));

        // LDI r1,0x2A
        ins = 16'h142A; ins_valid = 1'b1;
        exp_q.push_back(mk(1'b1, 2'd1, 8'h2A, 1'b0));
        tick();
        ins_valid = 1'b0;
        check("ldi_wb", 32'({EN, DIR_WR, DI, done}), 32'({1'b1, 2'd1, 8'h2A, 1'b1}));
        check("ldi_ready_low", 32'(ins_ready), 32'(0));
        tick();
        check("ldi_ready_back", 32'({ins_ready, EN}), 32'(2'b10));

        // ALU r3 <- r0,r1 with junk held on ins while busy
        alu_y = 8'h55; ins = 16'h2C40; ins_valid = 1'b1;
        exp_q.push_back(mk(1'b1, 2'd3, 8'h55, 1'b0));
        tick();
        ins = 16'h1FFF;
        check("read_addrs", 32'({EN, DIR_A, DIR_B}), 32'({1'b0, 2'd0, 2'd1}));
        check("read_ready", 32'(ins_ready), 32'(0));
        tick();
        ins = 16'h3000;
        check("exec_alu_op", 32'(alu_op), 32'(2));
        check("exec_en", 32'(EN), 32'(0));
        tick();
        check("alu_wb", 32'({EN, DIR_WR, DI, done}), 32'({1'b1, 2'd3, 8'h55, 1'b1}));
        ins = 16'hF000;
        exp_q.push_back(mk(1'b0, 2'd0, 8'h00, 1'b1));
        tick();
        check("alu_idle", 32'({EN, done}), 32'(0));

        // Illegal then NOP, back to back
        tick();
        check("ill_pulse", 32'({ill, done, EN}), 32'(3'b110));
        check("ill_ready", 32'(ins_ready), 32'(1));
        ins = 16'h0000;
        exp_q.push_back(mk(1'b0, 2'd0, 8'h00, 1'b0));
        tick();
        check("nop_done", 32'({ill, done, EN}), 32'(3'b010));
        ins_valid = 1'b0;
        tick();
        check("idle_quiet", 32'({ill, done, EN}), 32'(0));

        // Reset during EXEC drops the pending write
        alu_y = 8'h55; ins = 16'h2C40; ins_valid = 1'b1;
        tick();
        ins_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_outputs", 32'(outs_w), 32'(0));
        check("rst_ready", 32'(ins_ready), 32'(0));
        rst = 1'b0;
        #1;
        check("rst_idle_ready", 32'(ins_ready), 32'(1));
        tick();
        check("rst_no_write", 32'({EN, done}), 32'(0));

        // LDI r2,0x07 then ALU r2 <- r2,r2
        alu_y = 8'h0E; ins = 16'h1807; ins_valid = 1'b1;
        exp_q.push_back(mk(1'b1, 2'd2, 8'h07, 1'b0));
        exp_q.push_back(mk(1'b1, 2'd2, 8'h0E, 1'b0));
        tick();
        ins = 16'h2A80;
        check("b2b_ldi_wb", 32'({EN, DIR_WR, DI}), 32'({1'b1, 2'd2, 8'h07}));
        tick();
        check("b2b_gap_en", 32'(EN), 32'(0));
        tick();
        ins_valid = 1'b0;
        check("b2b_read", 32'({EN, DIR_A, DIR_B}), 32'({1'b0, 2'd2, 2'd2}));
        tick();
        tick();
        check("b2b_alu_wb", 32'({EN, DIR_WR, DI}), 32'({1'b1, 2'd2, 8'h0E}));
        tick();

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        check("accept_count", 32'(acc_q.size()), 32'(7));
        if (acc_q.size() == 7) begin
            check("ldi_to_alu_cycles", 32'(acc_q[1] - acc_q[0]), 32'(2));
            check("alu_to_ill_cycles", 32'(acc_q[2] - acc_q[1]), 32'(4));
            check("ill_to_nop_cycles", 32'(acc_q[3] - acc_q[2]), 32'(1));
            check("b2b_ldi_to_alu", 32'(acc_q[6] - acc_q[5]), 32'(2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
